// File: rtl/uart_rx_fifo.sv
// Receive-side frame buffer behind the UART receiver: first-word-fall-through
// FIFO drained by valid/ready, with sticky overflow and framing-error counting.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_done,
    input  logic                     rx_framing_error,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [7:0]               error_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             fe_prev;
    logic             frame_ok;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fe_event;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr];

    // A frame arriving with the framing error high is discarded outright.
    assign frame_ok = rx_done & !rx_framing_error;
    assign pop      = rd_valid & rd_ready;
    assign push     = frame_ok & (!full | pop);
    assign drop     = frame_ok & full & !pop;
    assign fe_event = rx_framing_error & !fe_prev;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow    <= 1'b0;
            fe_prev     <= 1'b0;
            error_count <= '0;
        end else begin
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
            fe_prev <= rx_framing_error;
            if (fe_event && error_count != '1) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 9;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_done = 1'b0;
    logic             rx_framing_error = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready = 1'b0;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clear_overflow = 1'b0;
    logic [7:0]       error_count;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_done          (rx_done),
        .rx_framing_error (rx_framing_error),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow),
        .error_count      (error_count)
    );

    always #5 clock = ~clock;

    // Reference model: a plain queue of frames plus flag/counter state.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    int               m_ec;
    bit               m_fe_prev;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_ovf     = 0;
            m_ec      = 0;
            m_fe_prev = 0;
        end else begin
            automatic int  sz  = m_q.size();
            automatic bit  p   = (sz > 0) && rd_ready;
            automatic bit  ok  = rx_done && !rx_framing_error;
            if (p) void'(m_q.pop_front());
            if (ok && (sz < DEPTH || p)) m_q.push_back(rx_data);
            if (ok && sz == DEPTH && !p) m_ovf = 1;
            else if (clear_overflow) m_ovf = 0;
            if (rx_framing_error && !m_fe_prev && m_ec < 255) m_ec++;
            m_fe_prev = rx_framing_error;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            chk("m_rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
            chk("m_count",    32'(count),    32'(m_q.size()));
            chk("m_full",     32'(full),     32'(m_q.size() == DEPTH));
            chk("m_empty",    32'(empty),    32'(m_q.size() == 0));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_err_cnt",  32'(error_count), 32'(m_ec));
            if (m_q.size() != 0) chk("m_rd_data", 32'(rd_data), 32'(m_q[0]));
        end
    end

    // Apply one cycle of stimulus, then return to idle 2 time units after the edge.
    task automatic cyc(input logic d, input logic [WIDTH-1:0] data, input logic rdy, input logic clr);
        rx_done        = d;
        rx_data        = data;
        rd_ready       = rdy;
        clear_overflow = clr;
        @(posedge clock);
        #2;
        rx_done        = 1'b0;
        rx_data        = '0;
        rd_ready       = 1'b0;
        clear_overflow = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_full",  32'(full), 0);

        // Single push / pop latency.
        cyc(1, 9'h1A5, 0, 0);
        chk("s1_valid", 32'(rd_valid), 1);
        chk("s1_data",  32'(rd_data), 32'h1A5);
        chk("s1_count", 32'(count), 1);
        chk("s1_empty", 32'(empty), 0);
        cyc(0, '0, 1, 0);
        chk("s1_empty2", 32'(empty), 1);
        chk("s1_count2", 32'(count), 0);

        // Fill, overflow drop, ordered drain, clear.
        for (int i = 0; i < 8; i++) cyc(1, 9'(i), 0, 0);
        chk("s2_full",  32'(full), 1);
        chk("s2_count", 32'(count), 8);
        cyc(1, 9'h0FF, 0, 0);
        chk("s2_ovf",    32'(overflow), 1);
        chk("s2_count9", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            chk("s2_order", 32'(rd_data), 32'(i));
            cyc(0, '0, 1, 0);
        end
        chk("s2_empty", 32'(empty), 1);
        chk("s2_ovf_kept", 32'(overflow), 1);
        cyc(0, '0, 0, 1);
        chk("s2_ovf_clr", 32'(overflow), 0);

        // Push while full with a simultaneous pop; pointers wrap.
        for (int i = 0; i < 8; i++) cyc(1, 9'(9'h100 + i), 0, 0);
        cyc(1, 9'h155, 1, 0);
        chk("s3_ovf",   32'(overflow), 0);
        chk("s3_count", 32'(count), 8);
        for (int i = 1; i < 8; i++) begin
            chk("s3_order", 32'(rd_data), 32'(9'h100 + i));
            cyc(0, '0, 1, 0);
        end
        chk("s3_last", 32'(rd_data), 32'h155);
        cyc(0, '0, 1, 0);
        chk("s3_empty", 32'(empty), 1);

        // Long framing-error levels count once each.
        for (int r = 0; r < 3; r++) begin
            rx_framing_error = 1'b1;
            repeat (40) cyc(0, '0, 0, 0);
            rx_framing_error = 1'b0;
            repeat (3) cyc(0, '0, 0, 0);
        end
        chk("s4_ec3",    32'(error_count), 3);
        chk("s4_count0", 32'(count), 0);

        // Frame coincident with a rising framing error is dropped, not an overflow.
        cyc(1, 9'h033, 0, 0);
        rx_framing_error = 1'b1;
        cyc(1, 9'h0AA, 0, 0);
        rx_framing_error = 1'b0;
        chk("s6_count", 32'(count), 1);
        chk("s6_ec",    32'(error_count), 4);
        chk("s6_ovf",   32'(overflow), 0);
        chk("s6_head",  32'(rd_data), 32'h033);
        cyc(0, '0, 1, 0);

        // Saturation of the error counter.
        for (int e = 0; e < 300; e++) begin
            rx_framing_error = 1'b1;
            cyc(0, '0, 0, 0);
            rx_framing_error = 1'b0;
            cyc(0, '0, 0, 0);
        end
        chk("s4_sat", 32'(error_count), 255);

        // Asynchronous reset mid-stream with count=5 and overflow set.
        for (int i = 0; i < 8; i++) cyc(1, 9'(9'h040 + i), 0, 0);
        cyc(1, 9'h1FF, 0, 0);
        repeat (3) cyc(0, '0, 1, 0);
        chk("s5_pre_count", 32'(count), 5);
        chk("s5_pre_ovf",   32'(overflow), 1);
        #1 reset = 1'b0;
        #1;
        chk("s5_count", 32'(count), 0);
        chk("s5_valid", 32'(rd_valid), 0);
        chk("s5_ovf",   32'(overflow), 0);
        chk("s5_ec",    32'(error_count), 0);
        chk("s5_empty", 32'(empty), 1);
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #2;
        cyc(1, 9'h1A5, 0, 0);
        chk("s5_valid2", 32'(rd_valid), 1);
        chk("s5_data2",  32'(rd_data), 32'h1A5);
        chk("s5_count2", 32'(count), 1);
        cyc(0, '0, 1, 0);
        chk("s5_empty2", 32'(empty), 1);
        repeat (2) cyc(0, '0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
